// File: rtl/mcu_spi_slave_pkg.sv
// Shared constants and helpers for the MCU SPI slave: target ids, MISO magic byte,
// frame byte-position states and target strobe decode.
package mcu_spi_slave_pkg;

    localparam logic [7:0] MCU_SYS_ID = 8'd1;
    localparam logic [7:0] MCU_HID_ID = 8'd2;
    localparam logic [7:0] MCU_OSD_ID = 8'd3;
    localparam logic [7:0] MCU_SDC_ID = 8'd4;
    localparam logic [7:0] MISO_MAGIC = 8'h5C;

    typedef enum logic [1:0] {
        BYTE_ID      = 2'd0,
        BYTE_CMD     = 2'd1,
        BYTE_PAYLOAD = 2'd2
    } byte_state_e;

    // Strobe vector ordering: bit0 sys, bit1 hid, bit2 osd, bit3 sdc.
    function automatic logic [3:0] target_onehot(input logic [7:0] id);
        logic [3:0] sel;
        case (id)
            MCU_SYS_ID: sel = 4'b0001;
            MCU_HID_ID: sel = 4'b0010;
            MCU_OSD_ID: sel = 4'b0100;
            MCU_SDC_ID: sel = 4'b1000;
            default:    sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a selectable idle value applied on reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave that demultiplexes MCU frames (id, command, payload) onto
// per-target byte strobes and returns the selected target's reply on MISO.
module mcu_spi_slave
    import mcu_spi_slave_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_in_start,
    output logic [7:0] data_in,
    output logic       sys_strobe,
    output logic       hid_strobe,
    output logic       osd_strobe,
    output logic       sdc_strobe,
    input  logic [7:0] sys_data_out,
    input  logic [7:0] hid_data_out,
    input  logic [7:0] osd_data_out,
    input  logic [7:0] sdc_data_out
);

    logic        csn_s;
    logic        sclk_s;
    logic        mosi_s;

    logic        sclk_prev_r;
    logic        csn_prev_r;
    logic [1:0]  settle_r;
    logic        armed_r;
    logic        active_r;
    logic [7:0]  rx_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  target_id_r;
    logic        reply_pend_r;
    logic [7:0]  tx_r;
    logic [3:0]  strobe_r;
    logic        start_r;
    logic [7:0]  data_in_r;

    byte_state_e byte_state_r;
    byte_state_e byte_state_next;
    logic [3:0]  strobe_next;
    logic        start_next;
    logic [7:0]  reply_s;

    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        csn_fall_s;
    logic        in_frame_s;
    logic        byte_done_s;
    logic [7:0]  rx_byte_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync_csn  (.clk(clk), .reset(reset), .d(spi_csn),  .q(csn_s));
    sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s));
    sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s));

    // A falling csn only opens a frame once the synchronizer has flushed its reset
    // value and csn has been seen genuinely high, so a reset mid-frame stays aborted.
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign csn_fall_s  = armed_r & csn_prev_r & ~csn_s;
    assign in_frame_s  = active_r & ~csn_s;
    assign byte_done_s = in_frame_s & sclk_rise_s & (bit_cnt_r == 3'd7);
    assign rx_byte_s   = {rx_r[6:0], mosi_s};

    // Reply byte of the currently addressed target
    always_comb begin
        reply_s = 8'h00;
        case (target_id_r)
            MCU_SYS_ID: reply_s = sys_data_out;
            MCU_HID_ID: reply_s = hid_data_out;
            MCU_OSD_ID: reply_s = osd_data_out;
            MCU_SDC_ID: reply_s = sdc_data_out;
            default:    reply_s = 8'h00;
        endcase
    end

    // Frame byte-position sequencing and strobe generation
    always_comb begin
        byte_state_next = byte_state_r;
        strobe_next     = 4'b0000;
        start_next      = 1'b0;
        if (!in_frame_s) begin
            byte_state_next = BYTE_ID;
        end else if (byte_done_s) begin
            case (byte_state_r)
                BYTE_ID: begin
                    byte_state_next = BYTE_CMD;
                end
                BYTE_CMD: begin
                    byte_state_next = BYTE_PAYLOAD;
                    strobe_next     = target_onehot(target_id_r);
                    start_next      = |target_onehot(target_id_r);
                end
                BYTE_PAYLOAD: begin
                    byte_state_next = BYTE_PAYLOAD;
                    strobe_next     = target_onehot(target_id_r);
                end
                default: begin
                    byte_state_next = BYTE_ID;
                end
            endcase
        end else begin
            byte_state_next = byte_state_r;
        end
    end

    // Edge history, frame arming and registered strobe outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev_r  <= 1'b0;
            csn_prev_r   <= 1'b1;
            settle_r     <= 2'd0;
            armed_r      <= 1'b0;
            active_r     <= 1'b0;
            byte_state_r <= BYTE_ID;
            strobe_r     <= 4'b0000;
            start_r      <= 1'b0;
            data_in_r    <= 8'h00;
        end else begin
            sclk_prev_r  <= sclk_s;
            csn_prev_r   <= csn_s;
            byte_state_r <= byte_state_next;
            strobe_r     <= strobe_next;
            start_r      <= start_next;
            if (settle_r != 2'd2) begin
                settle_r <= settle_r + 2'd1;
            end else if (csn_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
            if (csn_s) begin
                active_r <= 1'b0;
            end else if (csn_fall_s) begin
                active_r <= 1'b1;
            end else begin
                active_r <= active_r;
            end
            if (|strobe_next) begin
                data_in_r <= rx_byte_s;
            end else begin
                data_in_r <= data_in_r;
            end
        end
    end

    // Receive shifting, bit counting, target latch and MISO shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_r         <= 8'h00;
            bit_cnt_r    <= 3'd0;
            target_id_r  <= 8'h00;
            reply_pend_r <= 1'b0;
            tx_r         <= 8'h00;
        end else if (!in_frame_s) begin
            bit_cnt_r    <= 3'd0;
            target_id_r  <= 8'h00;
            reply_pend_r <= 1'b0;
            if (csn_fall_s) begin
                tx_r <= MISO_MAGIC;
            end else begin
                tx_r <= tx_r;
            end
        end else begin
            if (sclk_rise_s) begin
                rx_r      <= rx_byte_s;
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                rx_r      <= rx_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if (byte_done_s && (byte_state_r == BYTE_ID)) begin
                target_id_r <= rx_byte_s;
            end else begin
                target_id_r <= target_id_r;
            end
            if (byte_done_s) begin
                reply_pend_r <= 1'b1;
            end else if (sclk_fall_s) begin
                reply_pend_r <= 1'b0;
            end else begin
                reply_pend_r <= reply_pend_r;
            end
            if (sclk_fall_s) begin
                tx_r <= reply_pend_r ? reply_s : {tx_r[6:0], 1'b0};
            end else begin
                tx_r <= tx_r;
            end
        end
    end

    assign spi_miso      = tx_r[7];
    assign data_in_start = start_r;
    assign data_in       = data_in_r;
    assign sys_strobe    = strobe_r[0];
    assign hid_strobe    = strobe_r[1];
    assign osd_strobe    = strobe_r[2];
    assign sdc_strobe    = strobe_r[3];

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Self-checking bench for mcu_spi_slave: directed frames plus a randomized frame
// stream compared against a frame-level reference model.
module tb_mcu_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_csn, spi_sclk, spi_mosi, spi_miso;
    logic       data_in_start;
    logic [7:0] data_in;
    logic       sys_strobe, hid_strobe, osd_strobe, sdc_strobe;
    logic [7:0] sys_data_out, hid_data_out, osd_data_out, sdc_data_out;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] ev_q[$];      // observed {target, start, data}
    logic [11:0] exp_ev[$];
    logic [7:0]  fr_bytes[$];
    logic [31:0] fr_vals[$];   // {sdc, osd, hid, sys} presented during each byte
    int          fr_partial;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_miso[$];
    int          multi_err = 0;
    logic        watch_miso = 1'b0;
    int          miso_high = 0;

    always #5 clk = ~clk;

    mcu_spi_slave dut (
        .clk(clk), .reset(reset),
        .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .data_in_start(data_in_start), .data_in(data_in),
        .sys_strobe(sys_strobe), .hid_strobe(hid_strobe),
        .osd_strobe(osd_strobe), .sdc_strobe(sdc_strobe),
        .sys_data_out(sys_data_out), .hid_data_out(hid_data_out),
        .osd_data_out(osd_data_out), .sdc_data_out(sdc_data_out)
    );

    always @(negedge clk) begin
        if (int'(sys_strobe) + int'(hid_strobe) + int'(osd_strobe) + int'(sdc_strobe) > 1)
            multi_err++;
        if (sys_strobe) ev_q.push_back({3'd1, data_in_start, data_in});
        if (hid_strobe) ev_q.push_back({3'd2, data_in_start, data_in});
        if (osd_strobe) ev_q.push_back({3'd3, data_in_start, data_in});
        if (sdc_strobe) ev_q.push_back({3'd4, data_in_start, data_in});
        if (watch_miso && spi_miso) miso_high++;
    end

    task automatic xfer(input logic [7:0] b, input int nbits, input logic [31:0] vals,
                        input int half, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            repeat (half) @(negedge clk);
            r[7-i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            if (i == 7) {sdc_data_out, osd_data_out, hid_data_out, sys_data_out} = vals;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int half);
        logic [7:0] r;
        int nb;
        rx_q.delete();
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < fr_bytes.size(); k++) begin
            nb = (k == fr_bytes.size() - 1 && fr_partial != 0) ? fr_partial : 8;
            xfer(fr_bytes[k], nb, fr_vals[k], half, r);
            rx_q.push_back(r);
        end
        repeat (8) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Frame-level model: byte 0 reads the magic byte, byte k reads what the
    // addressed target presented during byte k-1; bytes 1.. are strobed.
    task automatic build_model();
        int tid, nfull;
        bit valid;
        logic [31:0] v;
        logic [7:0] t8;
        t8 = fr_bytes[0];
        tid = int'(t8);
        nfull = fr_bytes.size() - ((fr_partial != 0) ? 1 : 0);
        valid = (tid >= 1 && tid <= 4);
        exp_miso.delete();
        for (int k = 0; k < nfull; k++) begin
            if (k == 0) exp_miso.push_back(8'h5C);
            else if (valid) begin
                v = fr_vals[k-1] >> (8 * (tid - 1));
                exp_miso.push_back(v[7:0]);
            end else exp_miso.push_back(8'h00);
        end
        if (valid)
            for (int k = 1; k < nfull; k++)
                exp_ev.push_back({t8[2:0], (k == 1) ? 1'b1 : 1'b0, fr_bytes[k]});
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        {sdc_data_out, osd_data_out, hid_data_out, sys_data_out} = 32'h0;
        repeat (4) @(negedge clk);
        n_total++;
        if ({sys_strobe, hid_strobe, osd_strobe, sdc_strobe} !== 4'b0000)
            $display("FAIL reset_strobes got %b want 0000", {sys_strobe, hid_strobe, osd_strobe, sdc_strobe});
        else n_pass++;
        n_total++;
        if (data_in_start !== 1'b0) $display("FAIL reset_start got %b want 0", data_in_start);
        else n_pass++;
        n_total++;
        if (data_in !== 8'h00) $display("FAIL reset_data_in got %h want 00", data_in);
        else n_pass++;
        n_total++;
        if (spi_miso !== 1'b0) $display("FAIL reset_miso got %b want 0", spi_miso);
        else n_pass++;
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_hid_cmd();
        logic [11:0] want[2];
        logic [11:0] got;
        want[0] = {3'd2, 1'b1, 8'h01};
        want[1] = {3'd2, 1'b0, 8'h29};
        ev_q.delete();
        fr_bytes = '{8'h02, 8'h01, 8'h29};
        fr_vals = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        fr_partial = 0;
        run_frame(5);
        n_total++;
        if (ev_q.size() != 2) $display("FAIL hid_cmd_count got %0d want 2", ev_q.size());
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : 12'hxxx;
            n_total++;
            if (got !== want[i]) $display("FAIL hid_cmd_event%0d got %h want %h", i, got, want[i]);
            else n_pass++;
        end
        n_total++;
        if (rx_q[0] !== 8'h5C) $display("FAIL hid_cmd_magic got %h want 5c", rx_q[0]);
        else n_pass++;
    endtask

    task automatic test_miso_reply();
        logic [7:0] want[4];
        want[0] = 8'h5C; want[1] = 8'hA7; want[2] = 8'h01; want[3] = 8'h01;
        ev_q.delete();
        fr_bytes = '{8'h02, 8'h00, 8'hFF, 8'hFF};
        fr_vals = '{32'hEE00A7DD, 32'hEE0001DD, 32'hEE0001DD, 32'hEE0001DD};
        fr_partial = 0;
        run_frame(5);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rx_q[i] !== want[i]) $display("FAIL miso_reply_byte%0d got %h want %h", i, rx_q[i], want[i]);
            else n_pass++;
        end
        n_total++;
        if (ev_q.size() != 3) $display("FAIL miso_reply_events got %0d want 3", ev_q.size());
        else n_pass++;
    endtask

    task automatic test_bad_id();
        ev_q.delete();
        fr_bytes = '{8'h07, 8'h01, 8'h55};
        fr_vals = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        fr_partial = 0;
        run_frame(5);
        n_total++;
        if (ev_q.size() != 0) $display("FAIL bad_id_events got %0d want 0", ev_q.size());
        else n_pass++;
        for (int i = 1; i < 3; i++) begin
            n_total++;
            if (rx_q[i] !== 8'h00) $display("FAIL bad_id_miso%0d got %h want 00", i, rx_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_partial();
        logic [11:0] got;
        ev_q.delete();
        fr_bytes = '{8'h02, 8'h01, 8'hC3};
        fr_vals = '{32'h0, 32'h0, 32'h0};
        fr_partial = 5;
        run_frame(5);
        n_total++;
        if (ev_q.size() != 1) $display("FAIL partial_count got %0d want 1", ev_q.size());
        else n_pass++;
        ev_q.delete();
        fr_bytes = '{8'h03, 8'h10};
        fr_vals = '{32'h0, 32'h0};
        fr_partial = 0;
        run_frame(5);
        got = (ev_q.size() > 0) ? ev_q[0] : 12'hxxx;
        n_total++;
        if (ev_q.size() != 1 || got !== {3'd3, 1'b1, 8'h10})
            $display("FAIL partial_next_osd got %h (n=%0d) want %h", got, ev_q.size(), {3'd3, 1'b1, 8'h10});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        ev_q.delete();
        miso_high = 0;
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
        xfer(8'h02, 8, 32'hFFFFFFFF, 5, r);
        xfer(8'hA5, 4, 32'hFFFFFFFF, 5, r);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        watch_miso = 1'b1;
        xfer(8'h5A, 4, 32'hFFFFFFFF, 5, r);
        xfer(8'h01, 8, 32'hFFFFFFFF, 5, r);
        xfer(8'h33, 8, 32'hFFFFFFFF, 5, r);
        repeat (8) @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        watch_miso = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if (ev_q.size() != 0) $display("FAIL reset_mid_events got %0d want 0", ev_q.size());
        else n_pass++;
        n_total++;
        if (miso_high != 0) $display("FAIL reset_mid_miso got %0d high cycles want 0", miso_high);
        else n_pass++;
        fr_bytes = '{8'h02, 8'h01, 8'h29};
        fr_vals = '{32'h0, 32'h0, 32'h0};
        fr_partial = 0;
        run_frame(5);
        n_total++;
        if (ev_q.size() != 2 || ev_q[0] !== {3'd2, 1'b1, 8'h01} || ev_q[1] !== {3'd2, 1'b0, 8'h29})
            $display("FAIL reset_mid_recover got n=%0d want 2 hid events", ev_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int len, sel, bad;
        ev_q.delete();
        exp_ev.delete();
        multi_err = 0;
        bad = 0;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 5);
            sel = $urandom_range(0, 9);
            fr_bytes.delete();
            fr_vals.delete();
            if (sel < 8) fr_bytes.push_back(8'((sel % 4) + 1));
            else if (sel == 8) fr_bytes.push_back(8'h00);
            else fr_bytes.push_back(8'($urandom_range(5, 255)));
            fr_vals.push_back($urandom);
            for (int k = 1; k < len; k++) begin
                fr_bytes.push_back(8'($urandom));
                fr_vals.push_back($urandom);
            end
            fr_partial = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(4);
            build_model();
            for (int k = 0; k < exp_miso.size(); k++) begin
                n_total++;
                if (rx_q[k] !== exp_miso[k]) begin
                    $display("FAIL random_miso f%0d b%0d got %h want %h", f, k, rx_q[k], exp_miso[k]);
                    bad++;
                end else n_pass++;
            end
        end
        n_total++;
        if (ev_q.size() != exp_ev.size())
            $display("FAIL random_event_count got %0d want %0d", ev_q.size(), exp_ev.size());
        else n_pass++;
        for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
            n_total++;
            if (ev_q[i] !== exp_ev[i]) $display("FAIL random_event%0d got %h want %h", i, ev_q[i], exp_ev[i]);
            else n_pass++;
        end
        n_total++;
        if (multi_err != 0) $display("FAIL random_one_hot got %0d overlaps want 0", multi_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hid_cmd();
        test_miso_reply();
        test_bad_id();
        test_partial();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcu_spi_slave.md
MCU_SPI_SLAVE -- requirements
Module: mcu_spi_slave

Interface
REQ-001 clk  in  1  system clock; SHALL be at least 8x the SPI clock frequency.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 spi_csn  in  1  MCU chip select, active-low, asynchronous to clk.
REQ-004 spi_sclk  in  1  MCU SPI clock, mode 0 (sample on rising edge, shift on falling edge), asynchronous.
REQ-005 spi_mosi  in  1  MCU serial data, MSB first, asynchronous.
REQ-006 spi_miso  out  1  serial reply to the MCU, MSB first.
REQ-007 data_in_start  out  1  valid with a strobe; high only for the command byte.
REQ-008 data_in  out  8  last received byte, held until the next strobe.
REQ-009 sys_strobe, hid_strobe, osd_strobe, sdc_strobe  out  1 each  one-clk byte-valid pulse for each target.
REQ-010 sys_data_out, hid_data_out, osd_data_out, sdc_data_out  in  8 each  reply byte from each target.

Function
REQ-011 spi_csn, spi_sclk and spi_mosi SHALL each pass through a 2-FF synchronizer; edge detection SHALL use the synchronized sclk and its previous value.
REQ-012 Each synchronized sclk rising edge with csn low: shift mosi into the rx register and increment a 3-bit bit counter.
REQ-013 On the 8th rising edge (bit counter wraps 7->0), the byte is complete; data_in and the strobe SHALL be valid in the clk cycle after the edge is detected (latency 1 clk).
REQ-014 Frame byte index: byte 0 = target id; byte 1 = command; bytes 2+ = payload.
REQ-015 Byte 0 SHALL be latched as the target id and SHALL NOT generate any strobe.
REQ-016 Byte 1 SHALL pulse the matching target strobe with data_in_start=1; bytes 2+ SHALL pulse it with data_in_start=0.
REQ-017 Target ids: 1=sys, 2=hid, 3=osd, 4=sdc. Any other id: no strobes for the rest of the frame, and MISO shifts 0x00.
REQ-018 The frame byte index SHALL saturate at 2 (payload length is unlimited).
REQ-019 The tx register SHALL load 0x5C when the synchronized csn falls, so the MCU reads 0x5C during byte 0.
REQ-020 On the first sclk falling edge after a completed byte, tx SHALL load the selected target's data_out. The reply produced while byte N is received is therefore shifted out during byte N+1.
REQ-021 On all other sclk falling edges with csn low, tx SHALL shift left, filling with 0.
REQ-022 spi_miso SHALL equal tx[7] at all times.
REQ-023 Synchronized csn high: clear the bit counter, byte index and target id. A partial byte SHALL be discarded with no strobe.
REQ-024 At most one target strobe SHALL be high in any cycle; all strobes SHALL be low while csn is high.
REQ-025 sclk edges seen while csn is high SHALL be ignored.

Reset
REQ-026 Reset SHALL force: all strobes 0, data_in_start 0, data_in 0x00, tx 0x00 (so spi_miso 0), bit counter 0, byte index 0, target id 0, and synchronizers to idle (csn 1, sclk 0, mosi 0).
REQ-027 Reset asserted mid-frame SHALL abort the frame. Nothing SHALL be strobed until the next csn falling edge after reset is released.

Structure
REQ-028 A shared package SHALL hold the target-id constants (MCU_SYS_ID=1, MCU_HID_ID=2, MCU_OSD_ID=3, MCU_SDC_ID=4) and MISO_MAGIC=0x5C.
REQ-029 One sub-module, sync2 (generic 2-FF synchronizer), SHALL be instantiated three times; everything else SHALL be flat in mcu_spi_slave.

Verification
REQ-030 Frame 02,01,0x29 at sclk=clk/10 -> hid_strobe pulses twice: first with data_in_start=1, data_in=0x01; then with data_in_start=0, data_in=0x29. No other strobes fire.
REQ-031 Frame 02,00,FF,FF with hid_data_out driven 0x01 after the command byte -> MISO bytes read 0x5C, then the prior hid_data_out value, then 0x01.
REQ-032 Frame 07,01,55 -> no strobe of any kind; MISO bytes after byte 0 read 0x00.
REQ-033 csn raised after 5 bits of byte 2 -> no third strobe. The next frame 03,10 -> osd_strobe with start=1, data_in=0x10.
REQ-034 reset pulsed during byte 1 of a hid frame -> no strobe and spi_miso=0 until the next csn fall; the following full frame behaves normally.
REQ-035 Randomized 100-frame stream at sclk=clk/8 checked against a scoreboard -> every byte delivered once, in order, with the correct start flag and target.
